reorder_buffer: RTL
===================

// Module: reorder_buffer
// PURPOSE
//  In-order commit queue for the out-of-order core. Hands out rename tags at issue and
//  collects results from the CDB (common data bus: the result broadcast bus).
//  Retires the head entry to the register file as (tag, data) so the register file can
//  clear matching dependencies. Sits between the issue/foq stage, the execution units and
//  the register file.
// PARAMETERS
//  DEPTH   8   entries; tag = index+1, legal 2..15 (tag 0 = `None)
//  TAG_W   4   rename tag width, shared with register file and RS
// PORTS
//  clk_in        in   1      clock
//  rst_in        in   1      synchronous active-high reset
//  rdy_in        in   1      0 = pause: every register holds
//  flush_in      in   1      mispredict flush: discard all entries
//  alloc_valid   in   1      issue requests a new entry
//  alloc_rd      in   5      destination register of new entry
//  alloc_ready   out  1      entry free (count < DEPTH), combinational
//  alloc_tag     out  TAG_W  tag the next alloc receives (tail+1), combinational
//  wb_valid      in   1      CDB result valid
//  wb_tag        in   TAG_W  CDB result tag
//  wb_data       in   32     CDB result value
//  q1_tag        in   TAG_W  operand lookup 1 (qj)
//  q1_ready      out  1      tag q1_tag has a result (entry or same-cycle CDB)
//  q1_data       out  32     that result; 0 if not ready
//  q2_tag        in   TAG_W  operand lookup 2 (qk)
//  q2_ready      out  1      as q1
//  q2_data       out  32     as q1
//  commit_valid  out  1      registered; drives the register file mode (1 = rob update)
//  commit_tag    out  TAG_W  registered; retired tag (the register file's rob_depend)
//  commit_rd     out  5      registered; retired destination
//  commit_data   out  32     registered; retired value (the register file's rob_data)
// BEHAVIOUR
//  - Reset or flush: head=tail=count=0, all busy/ready cleared, commit_* = 0 next edge.
//  - Priority is flush > pause > normal. Reset/flush mid-operation drops every in-flight
//    entry. A wb or alloc in the flush cycle is ignored.
//  - Alloc fires when alloc_valid & alloc_ready. Entry[tail] = {busy=1, ready=0, rd}.
//    Tail wraps DEPTH-1 -> 0.
//  - alloc_ready is count<DEPTH, not credited by a same-cycle commit. A full ROB refuses
//    alloc even while it commits.
//  - Writeback: wb_valid with wb_tag in 1..DEPTH and entry busy & !ready sets
//    ready=1, data=wb_data. Any other wb is ignored: tag 0, out of range, or a free or
//    already-ready entry.
//  - Commit is at most 1 per cycle. If entry[head] is busy & ready at the clock edge:
//    commit_* <= {1, head+1, rd, data}, entry freed, head advances. Otherwise
//    commit_valid <= 0.
//  - Latency: wb in cycle N makes the entry ready at N+1. A head entry commits at edge
//    N+1, so commit_valid is visible in N+2.
//  - Simultaneous alloc+commit: count unchanged. Alloc into the slot freed by the same
//    commit cannot occur (alloc_ready was 0).
//  - Lookup (combinational): ready if entry busy & ready, or wb_valid & wb_tag==q_tag.
//    The CDB bypass wins. Tag 0 returns ready=0, data=0.
//  - Pause: no state changes and commit_* hold their value. The register file is also
//    paused, so a held commit pulse is consumed exactly once.
//  - Commit tags are unique among in-flight entries. A freed tag is reused only after
//    commit, so stale register-file dependencies are cleared before reuse.
// STRUCTURE
//  - Shared defines header: `None (4'b0), TAG_W, register index width (5), data width (32).
//    These are shared with the register file and the RS.
//  - Entry arrays busy/ready/rd/data, plus head/tail pointers of $clog2(DEPTH) bits and a
//    count register.
//  - No sub-module is needed. The two lookup ports are one function instantiated twice.
// TESTING
//  1 Reset, then alloc rd=5 -> alloc_tag=1, count=1. wb tag1 data=0xDEAD ->
//    2 cycles later commit_valid=1, tag=1, rd=5, data=0xDEAD.
//  2 Out-of-order wb: alloc tags 1,2,3, wb 3 then 2 then 1 -> commits 1,2,3 on
//    consecutive cycles after the wb of tag 1.
//  3 Fill all 8 -> alloc_ready=0. Commit tag1 while alloc_valid is held -> no alloc that
//    cycle; next cycle alloc_tag=1 (wrap) is granted.
//  4 Lookup q1_tag=2 in the cycle wb_tag=2, data=7 -> q1_ready=1, q1_data=7.
//    q2_tag=0 -> ready=0.
//  5 Four entries in flight, tag2 ready, flush_in=1 with a same-cycle wb -> count=0,
//    commit_valid=0, next alloc_tag=1.
//  6 rdy_in=0 for 3 cycles with a ready head -> no commit, pointers frozen.
//    rdy_in=1 -> commit resumes.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Definitions shared by the reorder buffer, the register file and the reservation stations.
package reorder_buffer_pkg;

   localparam int unsigned ROB_TAG_W = 4;
   localparam int unsigned REG_W     = 5;
   localparam int unsigned DATA_W    = 32;

   // Tag 0 means "no producer"; real tags are entry index + 1.
   localparam logic [ROB_TAG_W-1:0] NONE_TAG = '0;

   typedef struct packed {
      logic              ready;
      logic [DATA_W-1:0] data;
   } lookup_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit queue: hands out rename tags at issue, collects CDB results,
// retires the head entry to the register file as (tag, rd, data).
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned TAG_W = ROB_TAG_W
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush_in,
   input  logic              alloc_valid,
   input  logic [REG_W-1:0]  alloc_rd,
   output logic              alloc_ready,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_tag,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [TAG_W-1:0]  q1_tag,
   output logic              q1_ready,
   output logic [DATA_W-1:0] q1_data,
   input  logic [TAG_W-1:0]  q2_tag,
   output logic              q2_ready,
   output logic [DATA_W-1:0] q2_data,
   output logic              commit_valid,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [REG_W-1:0]  commit_rd,
   output logic [DATA_W-1:0] commit_data
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
   localparam logic [TAG_W-1:0] MAX_TAG  = TAG_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0]              head, tail;
   logic [CNT_W-1:0]              count;
   logic [DEPTH-1:0]              busy, rdy;
   logic [REG_W-1:0]              rd_q [DEPTH];
   logic [DEPTH-1:0][DATA_W-1:0]  data_q;

   logic             do_alloc, do_commit, do_wb, wb_in_range;
   logic [PTR_W-1:0] wb_idx;
   lookup_t          q1_res, q2_res;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // CDB bypass takes precedence over the stored entry.
   function automatic lookup_t lookup(
      input logic [TAG_W-1:0]             q,
      input logic                         wv,
      input logic [TAG_W-1:0]             wt,
      input logic [DATA_W-1:0]            wd,
      input logic [DEPTH-1:0]             b,
      input logic [DEPTH-1:0]             r,
      input logic [DEPTH-1:0][DATA_W-1:0] d
   );
      lookup_t          res;
      logic [PTR_W-1:0] idx;
      res = '0;
      idx = PTR_W'(q - 1'b1);
      if (q != TAG_W'(NONE_TAG)) begin
         if (wv && (wt == q)) begin
            res.ready = 1'b1;
            res.data  = wd;
         end else if ((q <= MAX_TAG) && b[idx] && r[idx]) begin
            res.ready = 1'b1;
            res.data  = d[idx];
         end
      end
      return res;
   endfunction

   assign alloc_ready = (count < FULL_CNT);
   assign alloc_tag   = TAG_W'(tail) + TAG_W'(1);

   assign wb_idx      = PTR_W'(wb_tag - 1'b1);
   assign wb_in_range = (wb_tag != TAG_W'(NONE_TAG)) && (wb_tag <= MAX_TAG);
   assign do_wb       = wb_valid && wb_in_range && busy[wb_idx] && !rdy[wb_idx];
   assign do_commit   = busy[head] && rdy[head];
   assign do_alloc    = alloc_valid && alloc_ready;

   always_comb begin
      q1_res = lookup(q1_tag, wb_valid, wb_tag, wb_data, busy, rdy, data_q);
      q2_res = lookup(q2_tag, wb_valid, wb_tag, wb_data, busy, rdy, data_q);
   end

   assign q1_ready = q1_res.ready;
   assign q1_data  = q1_res.data;
   assign q2_ready = q2_res.ready;
   assign q2_data  = q2_res.data;

   always_ff @(posedge clk_in) begin
      if (rst_in || flush_in) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         busy         <= '0;
         rdy          <= '0;
         commit_valid <= 1'b0;
         commit_tag   <= '0;
         commit_rd    <= '0;
         commit_data  <= '0;
      end else if (rdy_in) begin
         if (do_commit) begin
            busy[head]   <= 1'b0;
            rdy[head]    <= 1'b0;
            head         <= next_ptr(head);
            commit_valid <= 1'b1;
            commit_tag   <= TAG_W'(head) + TAG_W'(1);
            commit_rd    <= rd_q[head];
            commit_data  <= data_q[head];
         end else begin
            commit_valid <= 1'b0;
         end
         // A write-back never targets the committing head (already ready) nor the
         // allocating tail (free), so these per-entry updates cannot collide.
         if (do_wb) begin
            rdy[wb_idx] <= 1'b1;
         end
         if (do_alloc) begin
            busy[tail] <= 1'b1;
            rdy[tail]  <= 1'b0;
            tail       <= next_ptr(tail);
         end
         unique case ({do_alloc, do_commit})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && !flush_in && rdy_in) begin
         if (do_alloc) begin
            rd_q[tail] <= alloc_rd;
         end
         if (do_wb) begin
            data_q[wb_idx] <= wb_data;
         end
      end
   end

endmodule
